// File: rtl/f32_fpu_pkg.sv
// Shared types, constants and FP helpers for the f32 FPU scheduler.
// Helpers round/pack a normalised significand into IEEE-754 single.
package f32_fpu_pkg;

  localparam logic [1:0] ROUND_TONEAREST  = 2'b00;
  localparam logic [1:0] ROUND_TOWARDZERO = 2'b01;
  localparam logic [1:0] ROUND_DOWNWARD   = 2'b10;
  localparam logic [1:0] ROUND_UPWARD     = 2'b11;

  localparam logic OPSEL_ADD = 1'b0;
  localparam logic OPSEL_MUL = 1'b1;

  localparam int MAX_ID_W = 3;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct packed {
    logic [31:0]         op1;
    logic [31:0]         op2;
    logic                opsel;
    logic [1:0]          round;
    logic [MAX_ID_W-1:0] id;
  } req_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (&x[30:23]) && !(|x[22:0]);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return !(|x[30:0]);
  endfunction

  function automatic int unsigned lzc48(input logic [47:0] x);
    lzc48 = 48;
    for (int i = 0; i < 48; i++)
      if (x[i]) lzc48 = 32'(47 - i);
  endfunction

  // Right shift keeping every lost bit OR-ed into bit 0.
  function automatic logic [26:0] shr_sticky(input logic [26:0] m,
                                             input int unsigned n);
    logic [26:0] mask;
    if (n >= 27) return {26'd0, |m};
    mask = (27'd1 << n) - 27'd1;
    return (m >> n) | {26'd0, |(m & mask)};
  endfunction

  // m: [26] hidden bit, [25:3] fraction, [2:0] guard/round/sticky.
  // e: biased exponent of m[26]; values below 1 denormalise.
  function automatic logic [31:0] fp_pack(input logic s,
                                          input logic signed [9:0] e,
                                          input logic [26:0] m,
                                          input logic [1:0] rm);
    logic signed [9:0] ex;
    logic [26:0]       mm;
    logic              inc;
    logic [24:0]       mant;
    ex = e;
    mm = m;
    if (ex < 10'sd1) begin
      mm = shr_sticky(m, 32'(10'sd1 - ex));
      ex = 10'sd1;
    end
    unique case (rm)
      ROUND_TONEAREST:  inc = mm[2] & (mm[1] | mm[0] | mm[3]);
      ROUND_TOWARDZERO: inc = 1'b0;
      ROUND_DOWNWARD:   inc = s & (|mm[2:0]);
      ROUND_UPWARD:     inc = !s & (|mm[2:0]);
    endcase
    mant = {1'b0, mm[26:3]} + 25'(inc);
    if (mant[24]) begin
      mant = mant >> 1;
      ex   = ex + 10'sd1;
    end
    if (ex > 10'sd254) begin
      if (rm == ROUND_TOWARDZERO ||
          (rm == ROUND_DOWNWARD && !s) ||
          (rm == ROUND_UPWARD && s))
        return {s, 8'hFE, 23'h7FFFFF};
      return {s, 8'hFF, 23'd0};
    end
    return {s, mant[23] ? ex[7:0] : 8'd0, mant[22:0]};
  endfunction

endpackage

// File: rtl/F32Adder.sv
// Combinational IEEE-754 single-precision adder, four rounding modes.
// Operands are swapped so the larger magnitude is always on top.
module F32Adder
  import f32_fpu_pkg::*;
  (input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  rm,
   output logic [31:0] y);

  logic [31:0]       hi, lo;
  logic signed [9:0] eh, el, ex;
  logic [26:0]       mh, ml, mls, m;
  logic [27:0]       sum;
  logic              sub;
  int unsigned       d, sh;

  // Align, add or subtract, normalise, then round and pack.
  always_comb begin
    if (b[30:0] > a[30:0]) begin
      hi = b;
      lo = a;
    end else begin
      hi = a;
      lo = b;
    end
    eh  = (hi[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, hi[30:23]});
    el  = (lo[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, lo[30:23]});
    mh  = {hi[30:23] != 8'd0, hi[22:0], 3'b000};
    ml  = {lo[30:23] != 8'd0, lo[22:0], 3'b000};
    d   = 32'(eh - el);
    mls = shr_sticky(ml, d);
    sub = hi[31] ^ lo[31];
    sum = sub ? ({1'b0, mh} - {1'b0, mls})
              : ({1'b0, mh} + {1'b0, mls});
    ex  = eh;
    m   = sum[26:0];
    sh  = 0;
    if (sum[27]) begin
      m  = {sum[27:2], sum[1] | sum[0]};
      ex = eh + 10'sd1;
    end else begin
      sh = lzc48({m, 21'd0});
      if (sh > 32'(ex - 10'sd1)) sh = 32'(ex - 10'sd1);
      m  = m << sh;
      ex = ex - $signed(10'(sh));
    end
    if (is_nan(a) || is_nan(b))
      y = QNAN;
    else if (is_inf(a) && is_inf(b) && sub)
      y = QNAN;
    else if (is_inf(a))
      y = a;
    else if (is_inf(b))
      y = b;
    else if (sum == 28'd0)
      y = sub ? {rm == ROUND_DOWNWARD, 31'd0} : {hi[31], 31'd0};
    else
      y = fp_pack(hi[31], ex, m, rm);
  end

endmodule

// File: rtl/F32Multiplier.sv
// Combinational IEEE-754 single-precision multiplier.
// Product is left-normalised so subnormal inputs need no pre-pass.
module F32Multiplier
  import f32_fpu_pkg::*;
  (input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  rm,
   output logic [31:0] y);

  logic              s;
  logic signed [9:0] ea, eb, e;
  logic [23:0]       ma, mb;
  logic [47:0]       p, pn;
  logic [26:0]       m;
  int unsigned       lz;

  // Full product, normalise, then round and pack; specials override.
  always_comb begin
    s  = a[31] ^ b[31];
    ea = (a[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, a[30:23]});
    eb = (b[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, b[30:23]});
    ma = {a[30:23] != 8'd0, a[22:0]};
    mb = {b[30:23] != 8'd0, b[22:0]};
    p  = 48'(ma) * 48'(mb);
    lz = lzc48(p);
    pn = p << lz;
    e  = ea + eb - 10'sd126 - $signed(10'(lz));
    m  = {pn[47:22], |pn[21:0]};
    if (is_nan(a) || is_nan(b))
      y = QNAN;
    else if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b)))
      y = QNAN;
    else if (is_inf(a) || is_inf(b))
      y = {s, 8'hFF, 23'd0};
    else if (is_zero(a) || is_zero(b))
      y = {s, 31'd0};
    else
      y = fp_pack(s, e, m, rm);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Pointer moves past the winner only when a grant is issued.
module rr_arbiter
  #(parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1)
  (input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt,
   output logic [IW-1:0] idx);

  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  logic          hit;

  // Search from ptr upward, wrapping, for the first active request.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!hit && req[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
    gnt = (hit && en) ? (N'(1) << idx) : '0;
  end

  // Advance the pointer just past the granted index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (hit && en) ptr <= IW'((int'(idx) + 1) % N);
  end

endmodule

// File: rtl/f32_fpu_scheduler.sv
// Shares one FP adder and multiplier between N_REQ requesters
// through a round-robin grant into a 2-stage registered pipeline.
module f32_fpu_scheduler
  import f32_fpu_pkg::*;
  #(parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1)
  (input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req_valid,
   output logic [N_REQ-1:0]  req_ready,
   input  logic [32*N_REQ-1:0] req_op1,
   input  logic [32*N_REQ-1:0] req_op2,
   input  logic [N_REQ-1:0]  req_opsel,
   input  logic [2*N_REQ-1:0] req_round,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [31:0]       rsp_result,
   output logic [1:0]        occupancy);

  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv;
  req_t             s1, sel;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gidx;
  logic [31:0]      add_y, mul_y;

  assign s2_adv    = !s2_valid || rsp_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign req_ready = gnt;
  assign rsp_valid = s2_valid;
  assign occupancy = {1'b0, s1_valid} + {1'b0, s2_valid};

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (s1_adv),
    .gnt (gnt),
    .idx (gidx)
  );

  F32Adder u_add (
    .a  (s1.op1),
    .b  (s1.op2),
    .rm (s1.round),
    .y  (add_y)
  );

  F32Multiplier u_mul (
    .a  (s1.op1),
    .b  (s1.op2),
    .rm (s1.round),
    .y  (mul_y)
  );

  // Pick the winning requester's transaction fields.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gidx == ID_W'(i))
        sel = '{op1:   req_op1[i*32 +: 32],
                op2:   req_op2[i*32 +: 32],
                opsel: req_opsel[i],
                round: req_round[i*2 +: 2],
                id:    MAX_ID_W'(i)};
  end

  // S1: capture the granted request whenever the stage may advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_adv) begin
      s1_valid <= |gnt;
      if (|gnt) s1 <= sel;
    end
  end

  // S2: register the selected unit result; hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id     <= ID_W'(s1.id);
        rsp_result <= (s1.opsel == OPSEL_MUL) ? mul_y : add_y;
      end
    end
  end

endmodule

// File: tb/tb_f32_fpu_scheduler.sv
// Randomised bench for f32_fpu_scheduler against an in-order
// transaction-queue model with exactly representable FP operands.
module tb_f32_fpu_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [32*N-1:0] req_op1, req_op2;
  logic [N-1:0]  req_opsel;
  logic [2*N-1:0] req_round;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_result;
  logic [1:0]    occupancy;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [1:0]  rm;
    logic [31:0] exp;
  } txn_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    int          gc;
  } fl_t;

  txn_t cur [N];
  bit   vld [N];
  fl_t  pipe [$];
  int   gseq [$];
  int   ptr_m = 0;
  int   cyc = 0;
  int   mode = 0;
  int   last_g = -1;
  int   compared = 0;
  int   mismatched = 0;
  logic        obs_rv;
  logic [31:0] obs_id, obs_res, obs_occ;

  f32_fpu_scheduler #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opsel  (req_opsel),
    .req_round  (req_round),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = vld[i];
      req_op1[i*32 +: 32]  = cur[i].a;
      req_op2[i*32 +: 32]  = cur[i].b;
      req_opsel[i]         = cur[i].op;
      req_round[i*2 +: 2]  = cur[i].rm;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // n * 2^-sh as an IEEE single; n must fit in 24 bits.
  function automatic logic [31:0] q2f(input longint n, input int sh);
    logic        s;
    longint      m;
    int          p;
    logic [7:0]  e;
    logic [31:0] fr;
    s = n < 0;
    m = s ? -n : n;
    p = 0;
    for (int i = 0; i < 40; i++)
      if (((m >> i) & 64'd1) != 0) p = i;
    e  = 8'(p - sh + 127);
    fr = 32'((m << (23 - p)) & 64'h7FFFFF);
    return {s, e, fr[22:0]};
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    int   na, nb;
    na = int'($urandom_range(1, 256));
    nb = int'($urandom_range(1, 256));
    if ($urandom_range(0, 1) == 1) na = -na;
    if ($urandom_range(0, 1) == 1) nb = -nb;
    if ($urandom_range(0, 9) == 0) nb = -na;
    t.a  = q2f(longint'(na), 2);
    t.b  = q2f(longint'(nb), 2);
    t.op = 1'($urandom_range(0, 1));
    t.rm = 2'($urandom_range(0, 3));
    if (t.op == 1'b0) begin
      if (na + nb == 0)
        t.exp = (t.rm == 2'b10) ? 32'h80000000 : 32'h0;
      else
        t.exp = q2f(longint'(na + nb), 2);
    end else begin
      t.exp = q2f(longint'(na) * longint'(nb), 4);
    end
    return t;
  endfunction

  // Requester behaviour after each edge; never drops an unserved valid.
  task automatic refill(input int g);
    for (int i = 0; i < N; i++) begin
      if (g == i) begin
        if (mode == 0) begin
          vld[i] = 1'b0;
        end else begin
          cur[i] = rnd_txn();
          if (mode == 2) vld[i] = $urandom_range(0, 3) != 0;
        end
      end else if (!vld[i] && mode == 2) begin
        if ($urandom_range(0, 1) == 1) begin
          cur[i] = rnd_txn();
          vld[i] = 1'b1;
        end
      end
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge.
  task automatic step();
    int         g;
    logic       ev;
    logic [1:0] j;
    @(negedge clk);
    g = -1;
    if (pipe.size() < 2 || rsp_ready)
      for (int k = 0; k < N; k++) begin
        j = 2'(ptr_m + k);
        if (g < 0 && vld[j]) g = int'(j);
      end
    ev = pipe.size() > 0 && (cyc - pipe[0].gc >= 2);
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
    chk("occupancy", 32'(occupancy), 32'(pipe.size()));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk("rsp_id", 32'(rsp_id), 32'(pipe[0].id));
      chk("rsp_result", rsp_result, pipe[0].res);
    end
    obs_rv  = rsp_valid;
    obs_id  = 32'(rsp_id);
    obs_res = rsp_result;
    obs_occ = 32'(occupancy);
    @(posedge clk);
    if (ev && rsp_ready) void'(pipe.pop_front());
    if (g >= 0) begin
      pipe.push_back('{g, cur[g].exp, cyc});
      ptr_m = (g + 1) % N;
      gseq.push_back(g);
    end
    last_g = g;
    cyc++;
    #1;
    refill(g);
  endtask

  task automatic all_valid();
    for (int i = 0; i < N; i++) begin
      cur[i] = rnd_txn();
      vld[i] = 1'b1;
    end
  endtask

  task automatic drain();
    mode = 0;
    rsp_ready = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    int cnt, rsp_cnt;
    for (int i = 0; i < N; i++) begin
      cur[i] = '{32'h0, 32'h0, 1'b0, 2'b00, 32'h0};
      vld[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("model_q2f_pos", q2f(6, 2), 32'h3FC00000);
    chk("model_q2f_neg", q2f(-9, 2), 32'hC0100000);
    chk("model_q2f_prod", q2f(-24, 4), 32'hBFC00000);
    rst = 1'b0;

    // Fairness: everyone requesting, response always accepted.
    mode = 1;
    all_valid();
    gseq.delete();
    repeat (6) step();
    for (int i = 0; i < 6; i++)
      chk("fair_grant", 32'(gseq[i]), 32'(i % N));
    chk("fair_occupancy", obs_occ, 32'd2);
    drain();

    // Backpressure from an empty pipe: two accepts then stall.
    mode = 1;
    all_valid();
    rsp_ready = 1'b0;
    cnt = 0;
    repeat (6) begin
      step();
      if (last_g >= 0) cnt++;
    end
    chk("bp_accepts", 32'(cnt), 32'd2);
    chk("bp_occupancy", obs_occ, 32'd2);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    repeat (8) step();
    drain();

    // Single add on requester 0.
    cur[0] = '{32'h3FC00000, 32'h40100000, 1'b0, 2'b00, 32'h40700000};
    vld[0] = 1'b1;
    step();
    chk("add_grant", 32'(last_g), 32'd0);
    step();
    step();
    chk("add_rsp_valid", 32'(obs_rv), 32'd1);
    chk("add_rsp_id", obs_id, 32'd0);
    chk("add_rsp_result", obs_res, 32'h40700000);
    drain();

    // Single multiply on requester 2, then multiply by zero.
    cur[2] = '{32'h40400000, 32'h3F000000, 1'b1, 2'b00, 32'h3FC00000};
    vld[2] = 1'b1;
    step();
    step();
    step();
    chk("mul_rsp_id", obs_id, 32'd2);
    chk("mul_rsp_result", obs_res, 32'h3FC00000);
    cur[2] = '{32'h3F800000, 32'h00000000, 1'b1, 2'b00, 32'h00000000};
    vld[2] = 1'b1;
    step();
    step();
    step();
    chk("mulz_rsp_valid", 32'(obs_rv), 32'd1);
    chk("mulz_rsp_result", obs_res, 32'h00000000);
    drain();

    // Random traffic with random response backpressure.
    mode = 2;
    repeat (500) begin
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drain();

    // Asynchronous reset with a full pipe.
    mode = 1;
    all_valid();
    rsp_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    pipe.delete();
    ptr_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("rst_first_grant", 32'(last_g), 32'd0);
    repeat (4) step();
    drain();

    // Requester 1 alone, valid every other cycle.
    cnt = 0;
    rsp_cnt = 0;
    for (int r = 0; r < 10; r++) begin
      cur[1] = rnd_txn();
      vld[1] = 1'b1;
      step();
      if (last_g == 1) cnt++;
      if (obs_rv) rsp_cnt++;
      step();
      if (obs_rv) rsp_cnt++;
    end
    repeat (3) begin
      step();
      if (obs_rv) rsp_cnt++;
    end
    chk("gap_accepts", 32'(cnt), 32'd10);
    chk("gap_responses", 32'(rsp_cnt), 32'd10);

    // Requesters 0 and 1 alternate even across stall cycles.
    mode = 1;
    cur[0] = rnd_txn();
    cur[1] = rnd_txn();
    vld[0] = 1'b1;
    vld[1] = 1'b1;
    gseq.delete();
    repeat (16) begin
      rsp_ready = $urandom_range(0, 2) != 0;
      step();
    end
    for (int i = 1; i < gseq.size(); i++)
      chk("alt_grant", 32'(gseq[i]), 32'(1 - gseq[i-1]));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
